// File: rtl/ysyx_22050058_wb.sv
// Writeback stage: 2-entry bundle FIFO that commits one instruction per cycle to the register file.
// Latency: 1 cycle from acceptance into an empty FIFO to the registered commit outputs.
// Backpressure: wb_ready_o drops when full, halted or flushing; wb_stall_i holds the head entry.
module ysyx_22050058_wb #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid_i,
    output logic            wb_ready_o,
    input  logic [XLEN-1:0] wb_pc_i,
    input  logic            wb_dpicstop_i,
    input  logic [4:0]      wb_reg_waddr_i,
    input  logic            wb_we_i,
    input  logic [XLEN-1:0] wb_wdata_i,
    input  logic            wb_flush_i,
    input  logic            wb_stall_i,
    output logic            rf_we_o,
    output logic [4:0]      rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            commit_valid_o,
    output logic [XLEN-1:0] commit_pc_o,
    output logic            halt_o,
    output logic [1:0]      wb_count_o
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            stop;
        logic [4:0]      waddr;
        logic            we;
        logic [XLEN-1:0] wdata;
    } bundle_t;

    bundle_t    fifo_mem [2];
    bundle_t    head;
    bundle_t    in_bundle;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    // Ready is derived from registered state and flush only, never from wb_valid_i.
    assign wb_ready_o = (count != 2'd2) && !halt_o && !wb_flush_i;
    assign push       = wb_valid_i && wb_ready_o;
    assign pop        = (count != 2'd0) && !wb_stall_i && !halt_o && !wb_flush_i;
    assign head       = fifo_mem[rd_ptr];
    assign wb_count_o = count;

    assign in_bundle = '{pc: wb_pc_i, stop: wb_dpicstop_i, waddr: wb_reg_waddr_i,
                         we: wb_we_i, wdata: wb_wdata_i};

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_bundle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count          <= 2'd0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            rf_we_o        <= 1'b0;
            rf_waddr_o     <= 5'd0;
            rf_wdata_o     <= '0;
            commit_valid_o <= 1'b0;
            commit_pc_o    <= '0;
            halt_o         <= 1'b0;
        end else if (wb_flush_i) begin
            count          <= 2'd0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            rf_we_o        <= 1'b0;
            commit_valid_o <= 1'b0;
        end else begin
            rf_we_o        <= 1'b0;
            commit_valid_o <= 1'b0;
            if (pop) begin
                rf_we_o        <= head.we && (head.waddr != 5'd0);
                rf_waddr_o     <= head.waddr;
                rf_wdata_o     <= head.wdata;
                commit_valid_o <= 1'b1;
                commit_pc_o    <= head.pc;
            end
            // A retiring stop drops any younger entry, including one pushed on this edge.
            if (pop && head.stop) begin
                halt_o <= 1'b1;
                count  <= 2'd0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) wr_ptr <= ~wr_ptr;
                if (pop)  rd_ptr <= ~rd_ptr;
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050058_wb.sv
// Directed bench for the writeback FIFO: single commit, stall fill, x0 write, flush, stop and reset.
module tb_ysyx_22050058_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid_i;
    logic        wb_ready_o;
    logic [63:0] wb_pc_i;
    logic        wb_dpicstop_i;
    logic [4:0]  wb_reg_waddr_i;
    logic        wb_we_i;
    logic [63:0] wb_wdata_i;
    logic        wb_flush_i;
    logic        wb_stall_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [63:0] rf_wdata_o;
    logic        commit_valid_o;
    logic [63:0] commit_pc_o;
    logic        halt_o;
    logic [1:0]  wb_count_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_22050058_wb #(.XLEN(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_valid_i     (wb_valid_i),
        .wb_ready_o     (wb_ready_o),
        .wb_pc_i        (wb_pc_i),
        .wb_dpicstop_i  (wb_dpicstop_i),
        .wb_reg_waddr_i (wb_reg_waddr_i),
        .wb_we_i        (wb_we_i),
        .wb_wdata_i     (wb_wdata_i),
        .wb_flush_i     (wb_flush_i),
        .wb_stall_i     (wb_stall_i),
        .rf_we_o        (rf_we_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_wdata_o     (rf_wdata_o),
        .commit_valid_o (commit_valid_o),
        .commit_pc_o    (commit_pc_o),
        .halt_o         (halt_o),
        .wb_count_o     (wb_count_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic stop,
                         input logic [4:0] waddr, input logic we, input logic [63:0] wdata);
        wb_valid_i     = v;
        wb_pc_i        = pc;
        wb_dpicstop_i  = stop;
        wb_reg_waddr_i = waddr;
        wb_we_i        = we;
        wb_wdata_i     = wdata;
    endtask

    initial begin
        rst        = 1'b1;
        wb_flush_i = 1'b0;
        wb_stall_i = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 5'd0, 1'b0, 64'h0);
        step();
        step();
        check("rst_count", 64'(wb_count_o), 64'd0);
        check("rst_halt", 64'(halt_o), 64'd0);
        check("rst_commit", 64'(commit_valid_o), 64'd0);
        check("rst_rf_we", 64'(rf_we_o), 64'd0);
        rst = 1'b0;
        check("rst_ready", 64'(wb_ready_o), 64'd1);

        // Single bundle
        drive(1'b1, 64'h8000_0000, 1'b0, 5'd5, 1'b1, 64'h1234);
        step();
        drive(1'b0, 64'h0, 1'b0, 5'd0, 1'b0, 64'h0);
        check("single_count_after_push", 64'(wb_count_o), 64'd1);
        check("single_no_early_commit", 64'(commit_valid_o), 64'd0);
        step();
        check("single_commit", 64'(commit_valid_o), 64'd1);
        check("single_pc", commit_pc_o, 64'h8000_0000);
        check("single_rf_we", 64'(rf_we_o), 64'd1);
        check("single_waddr", 64'(rf_waddr_o), 64'd5);
        check("single_wdata", rf_wdata_o, 64'h1234);
        check("single_count_empty", 64'(wb_count_o), 64'd0);
        step();
        check("single_pulse_end", 64'(commit_valid_o), 64'd0);
        check("single_rf_we_end", 64'(rf_we_o), 64'd0);
        check("single_waddr_hold", 64'(rf_waddr_o), 64'd5);

        // Stall fill: two accepted, third refused until space frees
        wb_stall_i = 1'b1;
        drive(1'b1, 64'h100, 1'b0, 5'd1, 1'b1, 64'hA1);
        step();
        check("fill_count1", 64'(wb_count_o), 64'd1);
        drive(1'b1, 64'h104, 1'b0, 5'd2, 1'b1, 64'hB2);
        step();
        check("fill_count2", 64'(wb_count_o), 64'd2);
        check("fill_no_commit", 64'(commit_valid_o), 64'd0);
        drive(1'b1, 64'h108, 1'b0, 5'd3, 1'b1, 64'hC3);
        check("fill_ready_full", 64'(wb_ready_o), 64'd0);
        step();
        check("fill_count_held", 64'(wb_count_o), 64'd2);
        wb_stall_i = 1'b0;
        step();
        check("fill_commit_a", commit_pc_o, 64'h100);
        check("fill_commit_a_vld", 64'(commit_valid_o), 64'd1);
        check("fill_count_after_a", 64'(wb_count_o), 64'd1);
        step();
        drive(1'b0, 64'h0, 1'b0, 5'd0, 1'b0, 64'h0);
        check("fill_commit_b", commit_pc_o, 64'h104);
        check("fill_wdata_b", rf_wdata_o, 64'hB2);
        check("fill_count_pushpop", 64'(wb_count_o), 64'd1);
        step();
        check("fill_commit_c", commit_pc_o, 64'h108);
        check("fill_waddr_c", 64'(rf_waddr_o), 64'd3);
        check("fill_count_drained", 64'(wb_count_o), 64'd0);
        step();

        // Write to x0 retires without a register write
        drive(1'b1, 64'h200, 1'b0, 5'd0, 1'b1, 64'hDEAD);
        step();
        drive(1'b0, 64'h0, 1'b0, 5'd0, 1'b0, 64'h0);
        step();
        check("x0_commit", 64'(commit_valid_o), 64'd1);
        check("x0_rf_we", 64'(rf_we_o), 64'd0);
        check("x0_pc", commit_pc_o, 64'h200);
        step();

        // Flush with a push attempt on a full FIFO
        wb_stall_i = 1'b1;
        drive(1'b1, 64'h300, 1'b0, 5'd6, 1'b1, 64'h1);
        step();
        drive(1'b1, 64'h304, 1'b0, 5'd7, 1'b1, 64'h2);
        step();
        check("flush_pre_count", 64'(wb_count_o), 64'd2);
        wb_stall_i = 1'b0;
        wb_flush_i = 1'b1;
        drive(1'b1, 64'h308, 1'b0, 5'd8, 1'b1, 64'h3);
        check("flush_ready", 64'(wb_ready_o), 64'd0);
        step();
        wb_flush_i = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 5'd0, 1'b0, 64'h0);
        check("flush_count", 64'(wb_count_o), 64'd0);
        check("flush_no_commit", 64'(commit_valid_o), 64'd0);
        step();
        check("flush_nothing_left", 64'(commit_valid_o), 64'd0);

        // Stop instruction followed by a younger bundle
        drive(1'b1, 64'h8000_0010, 1'b1, 5'd9, 1'b1, 64'h55);
        step();
        drive(1'b1, 64'h8000_0014, 1'b0, 5'd10, 1'b1, 64'h66);
        step();
        check("stop_commit", 64'(commit_valid_o), 64'd1);
        check("stop_pc", commit_pc_o, 64'h8000_0010);
        check("stop_halt", 64'(halt_o), 64'd1);
        check("stop_count", 64'(wb_count_o), 64'd0);
        check("stop_ready", 64'(wb_ready_o), 64'd0);
        step();
        check("stop_no_more_commit", 64'(commit_valid_o), 64'd0);
        check("stop_halt_sticky", 64'(halt_o), 64'd1);
        check("stop_pc_hold", commit_pc_o, 64'h8000_0010);
        drive(1'b0, 64'h0, 1'b0, 5'd0, 1'b0, 64'h0);
        step();

        // Reset while halted
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_halt_cleared", 64'(halt_o), 64'd0);
        check("rst_pc_cleared", commit_pc_o, 64'd0);
        check("rst_waddr_cleared", 64'(rf_waddr_o), 64'd0);
        check("rst_wdata_cleared", rf_wdata_o, 64'd0);
        check("rst_ready_after", 64'(wb_ready_o), 64'd1);

        // Reset with an entry buffered
        wb_stall_i = 1'b1;
        drive(1'b1, 64'h400, 1'b0, 5'd4, 1'b1, 64'h7);
        step();
        drive(1'b0, 64'h0, 1'b0, 5'd0, 1'b0, 64'h0);
        check("rst2_pre_count", 64'(wb_count_o), 64'd1);
        rst = 1'b1;
        wb_stall_i = 1'b0;
        step();
        rst = 1'b0;
        check("rst2_count", 64'(wb_count_o), 64'd0);
        step();
        check("rst2_no_commit", 64'(commit_valid_o), 64'd0);
        check("rst2_ready", 64'(wb_ready_o), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
